mbm_product_accumulator: RTL and testbench



---
 rtl/mbm_pkg.sv | 23 ++
 rtl/mbm_sat_add.sv | 31 +++
 rtl/mbm_product_accumulator.sv | 81 ++++++++
 tb/tb_mbm_product_accumulator.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbm_pkg.sv
// Shared widths, FSM state type and saturation limits for the Booth MAC
// accumulate datapath.
package mbm_pkg;

  localparam int PROD_W_DEF = 32;
  localparam int ACC_W_DEF  = 40;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Limits are built at 64 bits and cast down by the user to its own ACC_W.
  function automatic logic [63:0] acc_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] acc_min(input int w);
    return ~acc_max(w);
  endfunction

endpackage

// File: rtl/mbm_sat_add.sv
// Combinational signed saturating adder: acc + sign-extended addend, clamped
// to the ACC_W signed range, with an overflow flag.
module mbm_sat_add
  import mbm_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PROD_W-1:0] addend,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));
  localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W));

  // One guard bit: the two top bits disagree exactly when the true sum
  // falls outside the ACC_W range.
  logic [ACC_W:0] wide;

  assign wide = {acc[ACC_W-1], acc}
              + {{(ACC_W + 1 - PROD_W){addend[PROD_W-1]}}, addend};
  assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];

  always_comb begin
    sum = wide[ACC_W-1:0];
    if (ovf) sum = wide[ACC_W] ? ACC_MIN : ACC_MAX;
  end

endmodule

// File: rtl/mbm_product_accumulator.sv
// Group accumulator for signed Booth products: saturating sum and count per
// in_last-terminated group, one registered result per group.
module mbm_product_accumulator
  import mbm_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_product,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_sat,
  output state_e                   state
);

  // Both sides use valid/ready: a beat moves on a rising edge where the
  // producer's valid and the consumer's ready are both high. in_ready is
  // high only in ACCUM and out_valid only in HOLD, so a group result is
  // held until taken and upstream stalls meanwhile.

  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    sat;

  logic signed [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0]        cnt_next;
  logic                    ovf;

  mbm_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_sat_add (
    .acc    (acc),
    .addend (in_product),
    .sum    (acc_next),
    .ovf    (ovf)
  );

  assign cnt_next  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (state == ACCUM) begin
      if (in_valid) begin
        if (in_last) begin
          out_acc   <= acc_next;
          out_count <= cnt_next;
          out_sat   <= sat | ovf;
          acc       <= '0;
          cnt       <= '0;
          sat       <= 1'b0;
          state     <= HOLD;
        end else begin
          acc <= acc_next;
          cnt <= cnt_next;
          sat <= sat | ovf;
        end
      end
    end else if (out_ready) begin
      state <= ACCUM;
    end
  end

endmodule

// File: tb/tb_mbm_product_accumulator.sv
// Bench for mbm_product_accumulator: three instances (default widths, narrow
// accumulator, narrow counter) checked against a plain-arithmetic group model.
module tb_mbm_product_accumulator;
  import mbm_pkg::*;

  localparam int RES_W = 81;

  logic clk, rst;
  logic [2:0] in_valid, out_ready;
  logic signed [31:0] in_product;
  logic in_last;

  logic signed [39:0] acc0, acc2;
  logic signed [33:0] acc1;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic sat0, sat1, sat2, ov0, ov1, ov2, rd0, rd1, rd2;
  state_e st0, st1, st2;

  mbm_product_accumulator #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) u_wide (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(rd0),
    .in_product(in_product), .in_last(in_last), .out_valid(ov0),
    .out_ready(out_ready[0]), .out_acc(acc0), .out_count(cnt0),
    .out_sat(sat0), .state(st0));

  mbm_product_accumulator #(.PROD_W(32), .ACC_W(34), .CNT_W(8)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(rd1),
    .in_product(in_product), .in_last(in_last), .out_valid(ov1),
    .out_ready(out_ready[1]), .out_acc(acc1), .out_count(cnt1),
    .out_sat(sat1), .state(st1));

  mbm_product_accumulator #(.PROD_W(32), .ACC_W(40), .CNT_W(2)) u_cnt (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(rd2),
    .in_product(in_product), .in_last(in_last), .out_valid(ov2),
    .out_ready(out_ready[2]), .out_acc(acc2), .out_count(cnt2),
    .out_sat(sat2), .state(st2));

  longint obs_acc[3];
  int     obs_cnt[3];
  logic   obs_sat[3], obs_valid[3], obs_ready[3];

  always_comb begin
    obs_acc[0] = longint'(acc0);  obs_acc[1] = longint'(acc1);  obs_acc[2] = longint'(acc2);
    obs_cnt[0] = int'(cnt0);      obs_cnt[1] = int'(cnt1);      obs_cnt[2] = int'(cnt2);
    obs_sat[0] = sat0;  obs_sat[1] = sat1;  obs_sat[2] = sat2;
    obs_valid[0] = ov0; obs_valid[1] = ov1; obs_valid[2] = ov2;
    obs_ready[0] = rd0; obs_ready[1] = rd1; obs_ready[2] = rd2;
  end

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int     n_vec = 0, n_bad = 0;
  int     acc_w[3], cnt_max[3];
  longint m_acc[3];
  int     m_cnt[3];
  bit     m_sat[3];
  logic [RES_W-1:0] exp_q[$];

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
    end
  endfunction

  function automatic void model_accept(input int idx, input longint p, input bit last);
    longint hi, lo;
    hi = (longint'(1) <<< (acc_w[idx] - 1)) - 1;
    lo = -hi - 1;
    m_acc[idx] = m_acc[idx] + p;
    if (m_acc[idx] > hi) begin m_acc[idx] = hi; m_sat[idx] = 1; end
    if (m_acc[idx] < lo) begin m_acc[idx] = lo; m_sat[idx] = 1; end
    if (m_cnt[idx] < cnt_max[idx]) m_cnt[idx]++;
    if (last) begin
      exp_q.push_back({64'(m_acc[idx]), 16'(m_cnt[idx]), m_sat[idx]});
      m_acc[idx] = 0; m_cnt[idx] = 0; m_sat[idx] = 0;
    end
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out waiting on handshake", name);
  endtask

  // ---------------- driver tasks (called #1 after a rising edge) ----------------
  task automatic send(input int idx, input logic signed [31:0] p, input bit last);
    int guard = 0;
    in_product = p;
    in_last    = last;
    in_valid[idx] = 1'b1;
    while (!obs_ready[idx] && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 100) timeout_fail("send");
    else model_accept(idx, longint'(p), last);
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
    in_product = $urandom();
    in_last = 1'($urandom_range(0, 1));
  endtask

  task automatic collect(input int idx, input string name);
    int guard = 0;
    logic [RES_W-1:0] e;
    longint held;
    out_ready[idx] = 1'b1;
    while (!obs_valid[idx] && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 100) begin
      timeout_fail(name);
      out_ready[idx] = 1'b0;
      return;
    end
    if (exp_q.size() == 0) begin
      timeout_fail({name, " empty queue"});
    end else begin
      e = exp_q.pop_front();
      check({name, " acc"}, obs_acc[idx], longint'(signed'(e[80:17])));
      check({name, " count"}, obs_cnt[idx], int'(e[16:1]));
      check({name, " sat"}, longint'(obs_sat[idx]), longint'(e[0]));
    end
    held = obs_acc[idx];
    @(posedge clk); #1;
    out_ready[idx] = 1'b0;
    check({name, " valid drop"}, longint'(obs_valid[idx]), 0);
    check({name, " acc held"}, obs_acc[idx], held);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_product = $urandom();
      @(posedge clk); #1;
    end
  endtask

  // ---------------- table of groups ----------------
  typedef struct {
    int                 idx;
    int                 n_rep;
    logic signed [31:0] prod_rep;
    logic signed [31:0] prod_last;
    longint             exp_acc;
    int                 exp_cnt;
    bit                 exp_sat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    acc_w   = '{40, 34, 40};
    cnt_max = '{255, 255, 3};
    vecs[0] = '{1, 8, 32'sd1073741824, 32'sd1073741824, 64'sd8589934591, 9, 1'b1};
    vecs[1] = '{1, 8, -32'sd2147450880, -32'sd2147450880, -64'sd8589934592, 9, 1'b1};
    vecs[2] = '{2, 4, 32'sd1, 32'sd1, 64'sd5, 3, 1'b0};
    vecs[3] = '{0, 0, 32'sd0, 32'sd7, 64'sd7, 1, 1'b0};
    vecs[4] = '{0, 2, 32'sh80000000, 32'sh7fffffff, -64'sd2147483649, 3, 1'b0};
    vecs[5] = '{1, 8, 32'sd1073741824, 32'sh80000000, 64'sd6442450943, 9, 1'b1};
    vecs[6] = '{2, 6, -32'sd1, 32'sd3, -64'sd3, 3, 1'b0};

    rst = 1'b1;
    in_valid = '0;
    out_ready = '0;
    in_product = '0;
    in_last = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("reset out_valid", longint'(ov0), 0);
    check("reset in_ready", longint'(rd0), 1);
    check("reset out_acc", obs_acc[0], 0);
    check("reset out_count", obs_cnt[0], 0);
    check("reset out_sat", longint'(sat0), 0);

    // Table-driven groups
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < vecs[v].n_rep; k++) send(vecs[v].idx, vecs[v].prod_rep, 1'b0);
      send(vecs[v].idx, vecs[v].prod_last, 1'b1);
      check($sformatf("vec%0d latency", v), longint'(obs_valid[vecs[v].idx]), 1);
      check($sformatf("vec%0d table acc", v), obs_acc[vecs[v].idx], vecs[v].exp_acc);
      check($sformatf("vec%0d table count", v), obs_cnt[vecs[v].idx], vecs[v].exp_cnt);
      check($sformatf("vec%0d table sat", v), longint'(obs_sat[vecs[v].idx]), longint'(vecs[v].exp_sat));
      collect(vecs[v].idx, $sformatf("vec%0d", v));
    end

    // Back-to-back 100, -30, 5 with one-cycle result latency
    send(0, 32'sd100, 1'b0);
    send(0, -32'sd30, 1'b0);
    send(0, 32'sd5, 1'b1);
    check("b2b latency", longint'(ov0), 1);
    check("b2b acc", obs_acc[0], 75);
    collect(0, "b2b");

    // Held result under backpressure while upstream keeps offering
    send(0, 32'sd7, 1'b1);
    in_valid[0] = 1'b1;
    in_product = 32'sd1;
    in_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d in_ready", c), longint'(rd0), 0);
      check($sformatf("hold%0d acc", c), obs_acc[0], 7);
    end
    in_valid[0] = 1'b0;
    collect(0, "hold");
    send(0, 32'sd1, 1'b0);
    send(0, 32'sd1, 1'b1);
    collect(0, "after hold");

    // Reset mid-group discards the partial sum
    send(0, 32'sd1000, 1'b0);
    send(0, 32'sd2000, 1'b0);
    rst = 1'b1;
    model_clear();
    #1;
    check("mid-reset out_valid", longint'(ov0), 0);
    check("mid-reset out_acc", obs_acc[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post-reset out_valid", longint'(ov0), 0);
    send(0, 32'sd3, 1'b1);
    check("post-reset acc", obs_acc[0], 3);
    check("post-reset count", obs_cnt[0], 1);
    collect(0, "post-reset");

    // Randomized groups on all three instances
    for (int g = 0; g < 40; g++) begin
      int idx, len;
      logic signed [31:0] p;
      idx = $urandom_range(0, 2);
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        idle($urandom_range(0, 2));
        p = $urandom();
        if ($urandom_range(0, 3) == 0) p = $urandom_range(0, 1) ? 32'sh7fffffff : 32'sh80000000;
        send(idx, p, k == len - 1);
      end
      idle($urandom_range(0, 3));
      collect(idx, $sformatf("rand%0d", g));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
